// File: rtl/mult_bus_master_if.sv
// Register-bus bundle between mult_bus_master and the multiplier peripheral.
// The master drives strobes, select and write data; the slave answers with read data and stalls.
interface mult_bus_master_if;
    logic        m_wstrb;
    logic        m_rstrb;
    logic [1:0]  m_sel;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_wbusy;
    logic        m_rbusy;

    modport master (
        output m_wstrb, m_rstrb, m_sel, m_wdata,
        input  m_rdata, m_wbusy, m_rbusy
    );

    modport slave (
        input  m_wstrb, m_rstrb, m_sel, m_wdata,
        output m_rdata, m_wbusy, m_rbusy
    );
endinterface

// File: rtl/mult_bus_master.sv
// Runs write A, write B, write START, wait, read RESULT on the multiplier bus per client request.
// Optional operand cache (skips repeated A/B writes) enabled by MULT_MASTER_OPCACHE_EN.
module mult_bus_master #(
    parameter int WAIT_CYCLES = 3,
    parameter int TIMEOUT     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [31:0]       op_a,
    input  logic [31:0]       op_b,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       result,
    mult_bus_master_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_A,
        S_WR_B,
        S_WR_GO,
        S_WAIT,
        S_RD,
        S_DONE
    } state_t;

    localparam logic [7:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;
    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);
    localparam state_t     AFTER_GO  = (WAIT_CYCLES > 0) ? S_WAIT : S_RD;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] result_q, result_d;
    logic        err_q, err_d;

    logic        wstrb, rstrb, stall, abort;
    logic [1:0]  sel;
    logic [31:0] wdata;
    logic        wr_a_done, wr_b_done;
    logic        skip_a, skip_b, skip_b_hold;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        err_d     = err_q;
        wstrb     = 1'b0;
        rstrb     = 1'b0;
        sel       = 2'b00;
        wdata     = '0;
        stall     = 1'b0;
        abort     = 1'b0;
        wr_a_done = 1'b0;
        wr_b_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    a_d   = op_a;
                    b_d   = op_b;
                    cnt_d = '0;
                    if (skip_a) state_d = skip_b ? S_WR_GO : S_WR_B;
                    else        state_d = S_WR_A;
                end
            end
            S_WR_A: begin
                wstrb = 1'b1;
                sel   = 2'b00;
                wdata = a_q;
                if (bus.m_wbusy) begin
                    stall = 1'b1;
                end else begin
                    wr_a_done = 1'b1;
                    state_d   = skip_b_hold ? S_WR_GO : S_WR_B;
                end
            end
            S_WR_B: begin
                wstrb = 1'b1;
                sel   = 2'b01;
                wdata = b_q;
                if (bus.m_wbusy) begin
                    stall = 1'b1;
                end else begin
                    wr_b_done = 1'b1;
                    state_d   = S_WR_GO;
                end
            end
            S_WR_GO: begin
                wstrb = 1'b1;
                sel   = 2'b10;
                wdata = 32'd1;
                if (bus.m_wbusy) stall = 1'b1;
                else             state_d = AFTER_GO;
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RD: begin
                rstrb = 1'b1;
                sel   = 2'b11;
                if (bus.m_rbusy) begin
                    stall = 1'b1;
                end else begin
                    result_d = bus.m_rdata;
                    err_d    = 1'b0;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // One counter serves both the WAIT delay and the stall watchdog; completions clear it.
        if (stall) begin
            if (cnt_q == TO_LAST) begin
                abort    = 1'b1;
                cnt_d    = '0;
                err_d    = 1'b1;
                result_d = '0;
                state_d  = S_DONE;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else if (wstrb || rstrb) begin
            cnt_d = '0;
        end
    end

    // NOTE: all state updates are non-blocking so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

`ifdef MULT_MASTER_OPCACHE_EN
    logic [31:0] last_a_q, last_a_d, last_b_q, last_b_d;
    logic        a_vld_q, a_vld_d, b_vld_q, b_vld_d;
    logic        skip_b_q, skip_b_d;

    assign skip_a      = a_vld_q && (op_a == last_a_q);
    assign skip_b      = b_vld_q && (op_b == last_b_q);
    assign skip_b_hold = skip_b_q;

    always_comb begin
        last_a_d = last_a_q;
        last_b_d = last_b_q;
        a_vld_d  = a_vld_q;
        b_vld_d  = b_vld_q;
        skip_b_d = skip_b_q;
        if (state_q == S_IDLE && req) skip_b_d = skip_b;
        if (wr_a_done) begin
            last_a_d = a_q;
            a_vld_d  = 1'b1;
        end
        if (wr_b_done) begin
            last_b_d = b_q;
            b_vld_d  = 1'b1;
        end
        // After an abort the peripheral's registers can no longer be trusted.
        if (abort) begin
            a_vld_d = 1'b0;
            b_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_a_q <= '0;
            last_b_q <= '0;
            a_vld_q  <= 1'b0;
            b_vld_q  <= 1'b0;
            skip_b_q <= 1'b0;
        end else begin
            last_a_q <= last_a_d;
            last_b_q <= last_b_d;
            a_vld_q  <= a_vld_d;
            b_vld_q  <= b_vld_d;
            skip_b_q <= skip_b_d;
        end
    end
`else
    logic unused_cache;
    assign skip_a       = 1'b0;
    assign skip_b       = 1'b0;
    assign skip_b_hold  = 1'b0;
    assign unused_cache = ^{wr_a_done, wr_b_done, abort};
`endif

    assign bus.m_wstrb = wstrb;
    assign bus.m_rstrb = rstrb;
    assign bus.m_sel   = sel;
    assign bus.m_wdata = wdata;

    assign busy   = state_q inside {S_WR_A, S_WR_B, S_WR_GO, S_WAIT, S_RD};
    assign done   = (state_q == S_DONE);
    assign err    = err_q;
    assign result = result_q;

endmodule
